// File: rtl/acc_pkg.sv
// Shared state encoding and default widths for the accumulate controller.
package acc_pkg;

  localparam int DEF_IN_DATA_WIDTH = 8;
  localparam int DEF_DWIDTH        = 16;
  localparam int DEF_AWIDTH        = 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/acc_dp.sv
// Sum register with synchronous clear and wrapping adder.
// Carry detect is present only when ACC_CTRL_OVF_EN is defined.
module acc_dp
  import acc_pkg::*;
#(
  parameter int IN_DATA_WIDTH = DEF_IN_DATA_WIDTH,
  parameter int DWIDTH        = DEF_DWIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr_i,
  input  logic                     add_en_i,
  input  logic [IN_DATA_WIDTH-1:0] data_i,
`ifdef ACC_CTRL_OVF_EN
  output logic                     ovf_o,
`endif
  output logic [DWIDTH-1:0]        sum_o
);

  logic [DWIDTH-1:0] sum_q;
  logic [DWIDTH-1:0] sum_d;

`ifdef ACC_CTRL_OVF_EN
  logic              ovf_q;
  logic [DWIDTH:0]   sum_ext;

  assign sum_ext = {1'b0, sum_q} + (DWIDTH+1)'(data_i);
  assign sum_d   = sum_ext[DWIDTH-1:0];
  assign ovf_o   = ovf_q;
`else
  assign sum_d   = sum_q + DWIDTH'(data_i);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
`ifdef ACC_CTRL_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else if (clr_i) begin
      sum_q <= '0;
`ifdef ACC_CTRL_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else if (add_en_i) begin
      sum_q <= sum_d;
`ifdef ACC_CTRL_OVF_EN
      // Sticky: any carry in the job marks the held result as wrapped.
      ovf_q <= ovf_q | sum_ext[DWIDTH];
`endif
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/acc_ctrl.sv
// Sequences N reads from operand memory and accumulates the returned data.
// Optional overflow_o port is enabled by ACC_CTRL_OVF_EN.
module acc_ctrl
  import acc_pkg::*;
#(
  parameter int IN_DATA_WIDTH = DEF_IN_DATA_WIDTH,
  parameter int DWIDTH        = DEF_DWIDTH,
  parameter int AWIDTH        = DEF_AWIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_i,
  input  logic [AWIDTH-1:0]        base_addr_i,
  input  logic [AWIDTH-1:0]        num_cnt_i,
  output logic                     mem_ce_o,
  output logic [AWIDTH-1:0]        mem_addr_o,
  input  logic [IN_DATA_WIDTH-1:0] mem_q_i,
  output logic                     busy_o,
  output logic                     done_o,
`ifdef ACC_CTRL_OVF_EN
  output logic                     overflow_o,
`endif
  output logic [DWIDTH-1:0]        result_o
);

  localparam logic [AWIDTH-1:0] ONE_A = {{(AWIDTH-1){1'b0}}, 1'b1};

  state_e            state_q;
  logic              ce_q;
  logic [AWIDTH-1:0] addr_q;
  logic [AWIDTH-1:0] cnt_q;
  logic              rvalid_q;
  logic              busy_q;
  logic              done_q;
  logic              accept_d;

  assign accept_d = (state_q == S_IDLE) && start_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ce_q     <= 1'b0;
      addr_q   <= '0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      rvalid_q <= ce_q;
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            busy_q <= 1'b1;
            if (num_cnt_i == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_FETCH;
              ce_q    <= 1'b1;
              addr_q  <= base_addr_i;
              // cnt_q counts reads still to issue after the current one.
              cnt_q   <= num_cnt_i - ONE_A;
            end
          end
        end
        S_FETCH: begin
          if (cnt_q == '0) begin
            state_q <= S_DRAIN;
            ce_q    <= 1'b0;
            addr_q  <= '0;
          end else begin
            addr_q <= addr_q + ONE_A;
            cnt_q  <= cnt_q - ONE_A;
          end
        end
        S_DRAIN: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  acc_dp #(
    .IN_DATA_WIDTH(IN_DATA_WIDTH),
    .DWIDTH       (DWIDTH)
  ) u_dp (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (accept_d),
    .add_en_i(rvalid_q),
    .data_i  (mem_q_i),
`ifdef ACC_CTRL_OVF_EN
    .ovf_o   (overflow_o),
`endif
    .sum_o   (result_o)
  );

  assign mem_ce_o   = ce_q;
  assign mem_addr_o = addr_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_acc_ctrl.sv
// Self-checking bench for acc_ctrl: directed corner jobs plus random jobs
// against a sum-of-memory model. Uses DWIDTH=8 when ACC_CTRL_OVF_EN is defined.
module tb_acc_ctrl;

`ifdef ACC_CTRL_OVF_EN
  localparam int DW = 8;
`else
  localparam int DW = 16;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start_i;
  logic [5:0]    base_addr_i;
  logic [5:0]    num_cnt_i;
  logic          mem_ce_o;
  logic [5:0]    mem_addr_o;
  logic [7:0]    mem_q_i;
  logic          busy_o;
  logic          done_o;
  logic [DW-1:0] result_o;
`ifdef ACC_CTRL_OVF_EN
  logic          overflow_o;
`endif

  logic [7:0] mem [64];
  int checks = 0;
  int errors = 0;

  acc_ctrl #(.IN_DATA_WIDTH(8), .DWIDTH(DW), .AWIDTH(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start_i),
    .base_addr_i(base_addr_i),
    .num_cnt_i  (num_cnt_i),
    .mem_ce_o   (mem_ce_o),
    .mem_addr_o (mem_addr_o),
    .mem_q_i    (mem_q_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
`ifdef ACC_CTRL_OVF_EN
    .overflow_o (overflow_o),
`endif
    .result_o   (result_o)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory; garbage is returned when no read was issued.
  always @(posedge clk) begin
    if (mem_ce_o) mem_q_i <= mem[mem_addr_o];
    else          mem_q_i <= 8'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
  endtask

  // One job from start to the IDLE cycle after done, checked every cycle.
  task automatic run_job(input int base, input int n);
    int total;
    int last;
    logic [31:0] exp_res;
    logic        exp_ovf;
    total = 0;
    for (int i = 0; i < n; i++) total += int'(mem[(base + i) % 64]);
    exp_res = 32'(total % (1 << DW));
    exp_ovf = (total >= (1 << DW));
    last = (n == 0) ? 1 : n + 2;
    @(negedge clk);
    start_i     = 1'b1;
    base_addr_i = 6'(base);
    num_cnt_i   = 6'(n);
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      start_i     = 1'b0;
      base_addr_i = 6'($urandom);
      num_cnt_i   = 6'($urandom);
      chk("ce", 32'(mem_ce_o), 32'(k <= n));
      chk("addr", 32'(mem_addr_o), (k <= n) ? 32'((base + k - 1) % 64) : 32'd0);
      chk("busy", 32'(busy_o), 32'd1);
      chk("done", 32'(done_o), 32'(k == last));
      if (k == last) begin
        chk("result", 32'(result_o), exp_res);
`ifdef ACC_CTRL_OVF_EN
        chk("ovf", 32'(overflow_o), 32'(exp_ovf));
`endif
      end
    end
    @(negedge clk);
    chk("idle_busy", 32'(busy_o), 32'd0);
    chk("idle_done", 32'(done_o), 32'd0);
    chk("idle_ce", 32'(mem_ce_o), 32'd0);
    chk("held_result", 32'(result_o), exp_res);
    $display("job base=%0d n=%0d result=%0h expected=%0h ovf_exp=%0d", base, n, result_o, exp_res, exp_ovf);
  endtask

  initial begin
    reset = 1'b1;
    start_i = 1'b0;
    base_addr_i = '0;
    num_cnt_i = '0;
    fill_random();
    repeat (3) @(negedge clk);
    chk("rst_ce", 32'(mem_ce_o), 32'd0);
    chk("rst_addr", 32'(mem_addr_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_result", 32'(result_o), 32'd0);
`ifdef ACC_CTRL_OVF_EN
    chk("rst_ovf", 32'(overflow_o), 32'd0);
`endif
    reset = 1'b0;

    // Small sequential sum.
    mem[0] = 8'd1; mem[1] = 8'd2; mem[2] = 8'd3; mem[3] = 8'd4;
    run_job(0, 4);
    // Zero-length job.
    run_job(17, 0);
    // Address wrap at the top of memory.
    run_job(62, 3);
    // Largest job, all ones data.
    for (int i = 0; i < 64; i++) mem[i] = 8'hFF;
    run_job(0, 63);

    // Reset in the middle of a fetch.
    fill_random();
    @(negedge clk);
    start_i = 1'b1; base_addr_i = 6'd10; num_cnt_i = 6'd10;
    repeat (3) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_ce", 32'(mem_ce_o), 32'd0);
    chk("midrst_addr", 32'(mem_addr_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_done", 32'(done_o), 32'd0);
    chk("midrst_result", 32'(result_o), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      chk("after_rst_done", 32'(done_o), 32'd0);
      chk("after_rst_busy", 32'(busy_o), 32'd0);
      chk("after_rst_result", 32'(result_o), 32'd0);
    end
    mem[20] = 8'd5; mem[21] = 8'd6;
    run_job(20, 2);
    chk("post_rst_sum", 32'(result_o), 32'd11);

    // Start held high: back-to-back single-operand jobs.
    mem[30] = 8'd7;
    @(negedge clk);
    start_i = 1'b1; base_addr_i = 6'd30; num_cnt_i = 6'd1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 12) start_i = 1'b0;
      chk("b2b_done", 32'(done_o), 32'(k % 4 == 3));
      chk("b2b_busy", 32'(busy_o), 32'(k % 4 != 0));
      if (done_o) chk("b2b_result", 32'(result_o), 32'd7);
      $display("b2b cycle=%0d done=%0d busy=%0d result=%0h", k, done_o, busy_o, result_o);
    end
    @(negedge clk);
    chk("b2b_stop", 32'(busy_o), 32'd0);

    // Random jobs.
    for (int j = 0; j < 16; j++) begin
      fill_random();
      run_job(int'($urandom_range(0, 63)),
              (j % 3 == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 5)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
